mm_burst: RTL

MM_BURST -- requirements
Module: mm_burst

---
 rtl/mm_pkg.sv | 16 +
 rtl/mm_array.sv | 23 ++
 rtl/mm_burst.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared defaults and the controller state encoding for the burst memory model.
package mm_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_LAT        = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RBURST = 2'd2,
    WBURST = 2'd3
  } mm_state_e;

endpackage

// File: rtl/mm_array.sv
// Word storage: synchronous write port, combinational read port.
module mm_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Contents start at zero and are never touched by reset.
  logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mm_burst.sv
// Line-burst memory model: fixed access latency, then critical-word-first
// read or write beats that wrap inside the aligned line.
//
// state  | meaning
// IDLE   | accepting a request (MMBusy low)
// WAIT   | latency down-counter running, LAT-1 cycles
// RBURST | one read beat per cycle on MemtoCache, MMValid high
// WBURST | one write beat per cycle from CachetoMem, MMWrAck high
module mm_burst
  import mm_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int LAT        = DEF_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MMRead,
  input  logic              MMWrite,
  input  logic [ADDR_W-1:0] ABUS,
  input  logic [DATA_W-1:0] CachetoMem,
  output logic [DATA_W-1:0] MemtoCache,
  output logic              MMBusy,
  output logic              MMValid,
  output logic              MMWrAck,
  output logic              MMDone
);

  localparam int L     = $clog2(LINE_WORDS);
  localparam int CNT_W = (LAT > 2) ? $clog2(LAT) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS - 1);
  localparam logic [L-1:0]      LAST_BEAT = L'(LINE_WORDS - 1);

  mm_state_e         state_q, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [L-1:0]      beat_q;
  logic [DATA_W-1:0] data_q;

  logic              req;
  logic              last_beat;
  logic [ADDR_W-1:0] rd_base;
  logic [L-1:0]      rd_beat;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] rd_data;
  logic              we;

  // Offset bits advance modulo the line; line bits are never carried into.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [L-1:0]      k);
    return (base & ~LINE_MASK) | ((base + ADDR_W'(k)) & LINE_MASK);
  endfunction

  assign req       = MMRead | MMWrite;
  assign last_beat = (beat_q == LAST_BEAT);

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (LAT == 1) state_nxt = MMRead ? RBURST : WBURST;
          else          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_nxt = wr_q ? WBURST : RBURST;
      end
      RBURST, WBURST: begin
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The read port is addressed one cycle ahead so MemtoCache can be registered.
  assign rd_base = (state_q == IDLE) ? ABUS : addr_q;
  assign rd_beat = (state_q == RBURST) ? beat_q + L'(1) : '0;
  assign rd_addr = beat_addr(rd_base, rd_beat);
  assign wr_addr = beat_addr(addr_q, beat_q);
  // Reset also suppresses the write of the beat it interrupts.
  assign we      = (state_q == WBURST) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (state_q == IDLE && req) begin
        addr_q <= ABUS;
        wr_q   <= ~MMRead;
        cnt_q  <= (LAT >= 2) ? CNT_W'(LAT - 2) : '0;
      end
      if (state_q == WAIT && cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
      if (state_q == RBURST || state_q == WBURST) beat_q <= last_beat ? '0 : beat_q + L'(1);
      if (state_nxt == RBURST) data_q <= rd_data;
    end
  end

  mm_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .we     (we),
    .wr_addr(wr_addr),
    .wr_data(CachetoMem),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  assign MemtoCache = data_q;
  assign MMBusy     = (state_q != IDLE);
  assign MMValid    = (state_q == RBURST);
  assign MMWrAck    = (state_q == WBURST);
  assign MMDone     = (state_q == RBURST || state_q == WBURST) && last_beat;

endmodule
